// File: rtl/exec_pkg.sv
// Shared execution-cluster types and helpers for the reservation stations.
package exec_pkg;

  localparam int unsigned ROBID_W = 7;
  localparam int unsigned RD_W    = 6;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 5;

  // mcalu op encodings: op[4:3]==2'b11 is MUL/DIV, op[2] selects DIV.
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00001;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b11000;
  localparam logic [OP_W-1:0] OP_MULH = 5'b11001;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b11100;
  localparam logic [OP_W-1:0] OP_REM  = 5'b11101;

  // Source operand: value when rdy, producer robid in val[ROBID_W-1:0] when busy.
  typedef struct packed {
    logic            rdy;
    logic [XLEN-1:0] val;
  } rs_operand_t;

  typedef struct packed {
    logic               valid;
    logic [OP_W-1:0]    op;
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0]    rd;
    rs_operand_t        op1;
    rs_operand_t        op2;
  } rs_entry_t;

  // True when a busy operand is waiting on the tag currently on the result bus.
  function automatic logic rs_wake_hit(rs_operand_t o, logic wb_v,
                                       logic [ROBID_W-1:0] wb_tag);
    return !o.rdy && wb_v && (o.val[ROBID_W-1:0] == wb_tag);
  endfunction

  // Capture the broadcast value into a matching busy operand.
  function automatic rs_operand_t rs_wake(rs_operand_t o, logic wb_v,
                                          logic [ROBID_W-1:0] wb_tag,
                                          logic [XLEN-1:0] wb_val);
    rs_operand_t r;
    r = o;
    if (rs_wake_hit(o, wb_v, wb_tag)) begin
      r.rdy = 1'b1;
      r.val = wb_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/exers_mc_prio_pick.sv
// Lowest-index priority picker: one-hot grant plus encoded index.
module prio_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IDX_W = $clog2(N);

  // Scan from the top so the lowest requesting index wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exers_mc.sv
// Collapsing-queue reservation station in front of the multi-cycle ALU.
// Optional feature macro: EXERS_WAKE_BYPASS_EN (wakeup-to-issue bypass).
module exers_mc
  import exec_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dis_valid,
  input  logic [OP_W-1:0]    dis_op,
  input  logic [ROBID_W-1:0] dis_robid,
  input  logic [RD_W-1:0]    dis_rd,
  input  logic               dis_op1_rdy,
  input  logic [XLEN-1:0]    dis_op1,
  input  logic               dis_op2_rdy,
  input  logic [XLEN-1:0]    dis_op2,
  output logic               exers_mc_stall,
  input  logic               wb_valid,
  input  logic [ROBID_W-1:0] wb_robid,
  input  logic [XLEN-1:0]    wb_result,
  output logic               exers_mcalu_issue,
  output logic [OP_W-1:0]    exers_mcalu_op,
  output logic [ROBID_W-1:0] exers_robid,
  output logic [RD_W-1:0]    exers_rd,
  output logic [XLEN-1:0]    exers_op1,
  output logic [XLEN-1:0]    exers_op2,
  input  logic               mcalu_stall,
  input  logic               rob_flush
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rs_entry_t          ent_q [DEPTH];
  rs_entry_t          ent_d [DEPTH];
  logic [CNT_W-1:0]   count_c;
  logic [DEPTH-1:0]   ready_c;
  logic [DEPTH-1:0]   sel_oh;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic               removed_c;
  logic               dis_acc_c;
  logic [CNT_W-1:0]   dis_slot_c;
  logic [XLEN-1:0]    opv1_c [DEPTH];
  logic [XLEN-1:0]    opv2_c [DEPTH];
  rs_entry_t          dis_ent_c;

  // Occupancy; entries are packed from slot 0 so this is also the first free slot.
  always_comb begin
    count_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_q[i].valid) count_c = count_c + CNT_W'(1);
    end
  end

  // Per-entry readiness and the operand values presented if that entry is selected.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef EXERS_WAKE_BYPASS_EN
      ready_c[i] = ent_q[i].valid
                 & (ent_q[i].op1.rdy | rs_wake_hit(ent_q[i].op1, wb_valid, wb_robid))
                 & (ent_q[i].op2.rdy | rs_wake_hit(ent_q[i].op2, wb_valid, wb_robid));
      opv1_c[i]  = ent_q[i].op1.rdy ? ent_q[i].op1.val : wb_result;
      opv2_c[i]  = ent_q[i].op2.rdy ? ent_q[i].op2.val : wb_result;
`else
      ready_c[i] = ent_q[i].valid & ent_q[i].op1.rdy & ent_q[i].op2.rdy;
      opv1_c[i]  = ent_q[i].op1.val;
      opv2_c[i]  = ent_q[i].op2.val;
`endif
    end
  end

  prio_pick #(.N(DEPTH)) u_pick (
    .req (ready_c),
    .gnt (sel_oh),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Issue port driven from the selected (oldest ready) entry.
  always_comb begin
    exers_mcalu_issue = sel_any & ~rob_flush;
    exers_mcalu_op    = '0;
    exers_robid       = '0;
    exers_rd          = '0;
    exers_op1         = '0;
    exers_op2         = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sel_oh[i]) begin
        exers_mcalu_op = ent_q[i].op;
        exers_robid    = ent_q[i].robid;
        exers_rd       = ent_q[i].rd;
        exers_op1      = opv1_c[i];
        exers_op2      = opv2_c[i];
      end
    end
  end

  // Handshake and dispatch acceptance; full is judged on registered state only.
  always_comb begin
    exers_mc_stall  = (count_c == CNT_W'(DEPTH));
    removed_c       = exers_mcalu_issue & ~mcalu_stall;
    dis_acc_c       = dis_valid & ~exers_mc_stall & ~rob_flush;
    dis_slot_c      = count_c - CNT_W'(removed_c);
    dis_ent_c.valid = 1'b1;
    dis_ent_c.op    = dis_op;
    dis_ent_c.robid = dis_robid;
    dis_ent_c.rd    = dis_rd;
    dis_ent_c.op1   = rs_wake('{rdy: dis_op1_rdy, val: dis_op1}, wb_valid, wb_robid, wb_result);
    dis_ent_c.op2   = rs_wake('{rdy: dis_op2_rdy, val: dis_op2}, wb_valid, wb_robid, wb_result);
  end

  // Next state: collapse over the removed slot, wake the shifted copy, append dispatch.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_d[i] = '0;
      if (removed_c && (i >= int'(sel_idx))) begin
        if (i < int'(DEPTH) - 1) ent_d[i] = ent_q[(i + 1) % int'(DEPTH)];
      end else begin
        ent_d[i] = ent_q[i];
      end
      ent_d[i].op1 = rs_wake(ent_d[i].op1, wb_valid, wb_robid, wb_result);
      ent_d[i].op2 = rs_wake(ent_d[i].op2, wb_valid, wb_robid, wb_result);
      if (dis_acc_c && (CNT_W'(i) == dis_slot_c)) ent_d[i] = dis_ent_c;
      if (rob_flush) ent_d[i] = '0;
    end
  end

  // Entry storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_exers_mc.sv
// Self-checking bench for exers_mc: directed scenarios plus random traffic,
// checked against an in-order queue model of the station.
module tb_exers_mc;

  localparam int DEPTH = 4;
`ifdef EXERS_WAKE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        dis_valid;
  logic [4:0]  dis_op;
  logic [6:0]  dis_robid;
  logic [5:0]  dis_rd;
  logic        dis_op1_rdy;
  logic [31:0] dis_op1;
  logic        dis_op2_rdy;
  logic [31:0] dis_op2;
  logic        exers_mc_stall;
  logic        wb_valid;
  logic [6:0]  wb_robid;
  logic [31:0] wb_result;
  logic        exers_mcalu_issue;
  logic [4:0]  exers_mcalu_op;
  logic [6:0]  exers_robid;
  logic [5:0]  exers_rd;
  logic [31:0] exers_op1;
  logic [31:0] exers_op2;
  logic        mcalu_stall;
  logic        rob_flush;

  exers_mc #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .dis_valid         (dis_valid),
    .dis_op            (dis_op),
    .dis_robid         (dis_robid),
    .dis_rd            (dis_rd),
    .dis_op1_rdy       (dis_op1_rdy),
    .dis_op1           (dis_op1),
    .dis_op2_rdy       (dis_op2_rdy),
    .dis_op2           (dis_op2),
    .exers_mc_stall    (exers_mc_stall),
    .wb_valid          (wb_valid),
    .wb_robid          (wb_robid),
    .wb_result         (wb_result),
    .exers_mcalu_issue (exers_mcalu_issue),
    .exers_mcalu_op    (exers_mcalu_op),
    .exers_robid       (exers_robid),
    .exers_rd          (exers_rd),
    .exers_op1         (exers_op1),
    .exers_op2         (exers_op2),
    .mcalu_stall       (mcalu_stall),
    .rob_flush         (rob_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [6:0]  robid;
    logic [5:0]  rd;
    bit          r1;
    logic [31:0] v1;
    bit          r2;
    logic [31:0] v2;
  } m_t;

  m_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(bit r, logic [31:0] v);
    return !r && wb_valid && (v[6:0] == wb_robid);
  endfunction

  function automatic bit m_rdy(bit r, logic [31:0] v);
    return r || (BYP && hit(r, v));
  endfunction

  function automatic m_t wake(m_t e);
    m_t w;
    w = e;
    if (hit(e.r1, e.v1)) begin w.r1 = 1'b1; w.v1 = wb_result; end
    if (hit(e.r2, e.v2)) begin w.r2 = 1'b1; w.v2 = wb_result; end
    return w;
  endfunction

  // One clock: check outputs against the queue model, then advance the model.
  task automatic cyc();
    int sel;
    bit stl, iss;
    m_t n;
    #1;
    stl = (q.size() == DEPTH);
    sel = -1;
    foreach (q[i]) if (sel < 0 && m_rdy(q[i].r1, q[i].v1) && m_rdy(q[i].r2, q[i].v2)) sel = i;
    iss = (sel >= 0) && !rob_flush;
    chk("stall", 32'(exers_mc_stall), 32'(stl));
    chk("issue", 32'(exers_mcalu_issue), 32'(iss));
    if (iss) begin
      chk("op",    32'(exers_mcalu_op), 32'(q[sel].op));
      chk("robid", 32'(exers_robid), 32'(q[sel].robid));
      chk("rd",    32'(exers_rd), 32'(q[sel].rd));
      chk("op1",   exers_op1, q[sel].r1 ? q[sel].v1 : wb_result);
      chk("op2",   exers_op2, q[sel].r2 ? q[sel].v2 : wb_result);
    end
    @(posedge clk);
    if (rob_flush) q.delete();
    else begin
      if (iss && !mcalu_stall) q.delete(sel);
      foreach (q[i]) q[i] = wake(q[i]);
      if (dis_valid && !stl) begin
        n.op = dis_op; n.robid = dis_robid; n.rd = dis_rd;
        n.r1 = dis_op1_rdy; n.v1 = dis_op1; n.r2 = dis_op2_rdy; n.v2 = dis_op2;
        q.push_back(wake(n));
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    dis_valid = 1'b0; dis_op = '0; dis_robid = '0; dis_rd = '0;
    dis_op1_rdy = 1'b0; dis_op1 = '0; dis_op2_rdy = 1'b0; dis_op2 = '0;
    wb_valid = 1'b0; wb_robid = '0; wb_result = '0;
    mcalu_stall = 1'b0; rob_flush = 1'b0;
  endtask

  task automatic dis(input logic [4:0] op, input logic [6:0] id, input logic [5:0] rd,
                     input bit r1, input logic [31:0] v1, input bit r2, input logic [31:0] v2);
    dis_valid = 1'b1; dis_op = op; dis_robid = id; dis_rd = rd;
    dis_op1_rdy = r1; dis_op1 = v1; dis_op2_rdy = r2; dis_op2 = v2;
  endtask

  task automatic wb(input logic [6:0] tag, input logic [31:0] val);
    wb_valid = 1'b1; wb_robid = tag; wb_result = val;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete();

    // Reset state
    #1;
    chk("rst_stall", 32'(exers_mc_stall), 32'd0);
    chk("rst_issue", 32'(exers_mcalu_issue), 32'd0);
    cyc();

    // 1: ready MUL issues the cycle after dispatch
    dis(5'b11000, 7'd5, 6'd1, 1'b1, 32'd3, 1'b1, 32'd7);
    cyc();
    idle();
    #1;
    chk("t1_issue", 32'(exers_mcalu_issue), 32'd1);
    chk("t1_robid", 32'(exers_robid), 32'd5);
    chk("t1_op1", exers_op1, 32'd3);
    chk("t1_op2", exers_op2, 32'd7);
    cyc();
    #1;
    chk("t1_empty", 32'(exers_mcalu_issue), 32'd0);
    cyc();

    // 2: wakeup from the result bus
    dis(5'b00000, 7'd9, 6'd2, 1'b0, 32'd4, 1'b1, 32'd1);
    cyc();
    idle();
    cyc();
    wb(7'd4, 32'hDEAD);
    #1;
    chk("t2_wake_cycle", 32'(exers_mcalu_issue), 32'(BYP));
    cyc();
    idle();
    #1;
    chk("t2_next_cycle", 32'(exers_mcalu_issue), 32'(!BYP));
    if (!BYP) chk("t2_op1", exers_op1, 32'hDEAD);
    cyc();

    // 3: fill, drop when full, retry after an entry leaves
    for (int i = 0; i < DEPTH; i++) begin
      dis(5'b11100, 7'(20 + i), 6'(i), 1'b1, 32'(100 + i), 1'b0, 32'd60);
      cyc();
    end
    dis(5'b00001, 7'd24, 6'd9, 1'b1, 32'd11, 1'b1, 32'd12);
    #1;
    chk("t3_full", 32'(exers_mc_stall), 32'd1);
    cyc();
    wb(7'd60, 32'h600D);
    cyc();
    wb_valid = 1'b0;
    cyc();
    cyc();
    idle();
    repeat (6) cyc();
    chk("t3_drained", 32'(q.size()), 32'd0);

    // 4: stall holds the oldest ready entry stable
    dis(5'b11001, 7'd1, 6'd3, 1'b1, 32'd10, 1'b1, 32'd20);
    cyc();
    dis(5'b11001, 7'd2, 6'd4, 1'b1, 32'd30, 1'b1, 32'd40);
    mcalu_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_hold", 32'(exers_robid), 32'd1);
      cyc();
      idle();
      mcalu_stall = 1'b1;
    end
    mcalu_stall = 1'b0;
    #1;
    chk("t4_rel", 32'(exers_robid), 32'd1);
    cyc();
    #1;
    chk("t4_next", 32'(exers_robid), 32'd2);
    cyc();

    // 5: issue + wakeup + dispatch in one cycle
    mcalu_stall = 1'b1;
    dis(5'b00000, 7'd30, 6'd5, 1'b1, 32'd1, 1'b1, 32'd2);
    cyc();
    dis(5'b00000, 7'd31, 6'd6, 1'b0, 32'd70, 1'b1, 32'd3);
    cyc();
    dis(5'b00000, 7'd32, 6'd7, 1'b1, 32'd4, 1'b0, 32'd71);
    cyc();
    idle();
    dis(5'b00000, 7'd33, 6'd8, 1'b1, 32'd5, 1'b1, 32'd6);
    wb(7'd71, 32'hCAFE);
    cyc();
    idle();
    mcalu_stall = 1'b1;
    #1;
    chk("t5_count", 32'(q.size()), 32'd3);
    if (!BYP) begin
      chk("t5_sel", 32'(exers_robid), 32'd32);
      chk("t5_wok", exers_op2, 32'hCAFE);
    end
    cyc();
    idle();
    wb(7'd70, 32'hBEEF);
    cyc();
    idle();
    repeat (5) cyc();

    // 6: flush beats dispatch
    for (int i = 0; i < 3; i++) begin
      dis(5'b00000, 7'(40 + i), 6'(i), 1'b0, 32'd80, 1'b1, 32'd0);
      cyc();
    end
    dis(5'b00000, 7'd50, 6'd1, 1'b1, 32'd1, 1'b1, 32'd1);
    rob_flush = 1'b1;
    cyc();
    idle();
    #1;
    chk("t6_issue", 32'(exers_mcalu_issue), 32'd0);
    chk("t6_stall", 32'(exers_mc_stall), 32'd0);
    cyc();
    wb(7'd80, 32'h1);
    cyc();
    idle();
    cyc();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(0, 2) != 0)
        dis(5'($urandom), 7'($urandom_range(0, 15)), 6'($urandom),
            1'($urandom), {25'($urandom), 7'($urandom_range(0, 15))},
            1'($urandom), {25'($urandom), 7'($urandom_range(0, 15))});
      if ($urandom_range(0, 1) != 0) wb(7'($urandom_range(0, 15)), $urandom);
      mcalu_stall = ($urandom_range(0, 3) == 0);
      rob_flush   = ($urandom_range(0, 39) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
